fft32_input_loader: RTL and testbench

- Upstream stage of the 32-point FFT core.
- Accepts time-domain samples one per cycle over a valid/ready stream and assembles them into a 32-sample frame in a fill buffer.
- Transfers each complete frame into a holding register that drives the FFT core's 32 parallel 24-bit sample inputs, and issues the one-cycle start pulse.
- Blocks a new transfer until the core's fixed compute window has elapsed. Double buffering lets frame n+1 fill while frame n is processed.

---
 rtl/fft32_input_loader.sv | 125 ++++++++++++
 tb/tb_fft32_input_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft32_input_loader.sv
// Input stage of the 32-point FFT: collects a streamed frame, hands it to the core as
// one wide word with a start pulse, and keeps that word stable for the core's compute window.
module fft32_input_loader #(
  parameter int DATA_W      = 24,
  parameter int N           = 32,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic [N*DATA_W-1:0] xn_bus,
  output logic                start,
  output logic                busy,
  output logic                frame_err,
  output logic [15:0]         frame_cnt
);

  localparam int IDX_W = $clog2(N);
  localparam int HC_W  = 8;
  localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic                fill_full_q, fill_full_d;
  logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                frame_err_q, frame_err_d;
  logic                start_q;
  logic                busy_q;
  logic                ready_en_q;
  logic [N*DATA_W-1:0] xn_q;
  logic [N*DATA_W-1:0] fill_flat;

  logic accept;
  logic transfer;

  // ready_en_q keeps in_ready low until the first edge after reset release
  assign in_ready = ready_en_q && !fill_full_q;
  assign accept   = in_valid && in_ready;
  assign transfer = fill_full_q && (hold_cnt_q == '0);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      logic [DATA_W-1:0] slot_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_q <= '0;
        end else if (accept && (wr_idx_q == IDX_W'(gi))) begin
          slot_q <= in_data;
        end
      end
      assign fill_flat[gi*DATA_W +: DATA_W] = slot_q;
    end
  endgenerate

  always_comb begin
    wr_idx_d    = wr_idx_q;
    fill_full_d = fill_full_q;
    hold_cnt_d  = hold_cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = 1'b0;

    // A partial frame or an unterminated one is dropped; the fill restarts at slot 0
    if (accept) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d = '0;
        if (in_last) begin
          fill_full_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else if (in_last) begin
        wr_idx_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end

    if (transfer) begin
      fill_full_d = 1'b0;
      hold_cnt_d  = HOLD_LOAD;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q    <= '0;
      fill_full_q <= 1'b0;
      hold_cnt_q  <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_en_q  <= 1'b0;
      xn_q        <= '0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      fill_full_q <= fill_full_d;
      hold_cnt_q  <= hold_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
      start_q     <= transfer;
      busy_q      <= (hold_cnt_d != '0);
      ready_en_q  <= 1'b1;
      if (transfer) begin
        xn_q <= fill_flat;
      end
    end
  end

  assign xn_bus    = xn_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft32_input_loader.sv
// Directed bench for fft32_input_loader: one instance with the default hold window and
// one with a 40-cycle window, sharing a stream driver selected by sel.
module tb_fft32_input_loader;

  localparam int W  = 24;
  localparam int NS = 32;
  localparam int BW = NS * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_last, sel;
  logic [W-1:0]  in_data;

  logic          in_valid1, in_ready1, start1, busy1, frame_err1;
  logic [BW-1:0] xn1;
  logic [15:0]   frame_cnt1;
  logic          in_valid2, in_ready2, start2, busy2, frame_err2;
  logic [BW-1:0] xn2;
  logic [15:0]   frame_cnt2;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int st_n1 = 0, st_n2 = 0, err_n1 = 0, xn_viol = 0;
  int st_cyc1 [16];
  int st_cyc2 [16];
  logic [BW-1:0] st_xn1 [16];
  logic [BW-1:0] st_xn2 [16];
  logic [BW-1:0] prev_xn1;
  logic          prev_rst = 1'b0;

  assign in_valid1 = in_valid && !sel;
  assign in_valid2 = in_valid && sel;

  always #5 clk = ~clk;

  fft32_input_loader #(.DATA_W(W), .N(NS), .HOLD_CYCLES(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .xn_bus(xn1), .start(start1),
    .busy(busy1), .frame_err(frame_err1), .frame_cnt(frame_cnt1)
  );

  fft32_input_loader #(.DATA_W(W), .N(NS), .HOLD_CYCLES(40)) u_dut40 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .xn_bus(xn2), .start(start2),
    .busy(busy2), .frame_err(frame_err2), .frame_cnt(frame_cnt2)
  );

  always @(posedge clk) cyc++;

  // Event log taken on the falling edge, away from the edge that updates the DUT
  always @(negedge clk) begin
    if (start1 === 1'b1 && st_n1 < 16) begin
      st_cyc1[st_n1] = cyc;
      st_xn1[st_n1]  = xn1;
      st_n1++;
    end
    if (start2 === 1'b1 && st_n2 < 16) begin
      st_cyc2[st_n2] = cyc;
      st_xn2[st_n2]  = xn2;
      st_n2++;
    end
    if (frame_err1 === 1'b1) err_n1++;
    if (rst_n && prev_rst && (xn1 !== prev_xn1) && start1 !== 1'b1) xn_viol++;
    prev_xn1 = xn1;
    prev_rst = rst_n;
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    bit acc;
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 100) begin
      acc = sel ? in_ready2 : in_ready1;
      tick();
      guard++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [W-1:0] base, input logic with_last);
    for (int k = 0; k < NS; k++) send(base + W'(k), with_last && (k == NS - 1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_starts(input bit which, input int target, input string tag);
    int guard = 0;
    while (((which ? st_n2 : st_n1) < target) && guard < 200) begin
      tick();
      guard++;
    end
    chk(tag, ((which ? st_n2 : st_n1) >= target), 1);
  endtask

  function automatic logic [BW-1:0] frame_of(input logic [W-1:0] base, input logic [W-1:0] step);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < NS; k++) v[k*W +: W] = base + W'(k) * step;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    logic [BW-1:0] fa, fb;
    fa = frame_of(24'h100000, 24'd1);
    fb = frame_of(24'h200000, 24'd1);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; sel = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", in_ready1, 0);
    chk("rst_xn_bus", xn1, 0);
    chk("rst_start", start1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_frame_err", frame_err1, 0);
    chk("rst_frame_cnt", frame_cnt1, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", in_ready1, 1);

    // Single frame of k*0x000101
    for (int k = 0; k < NS; k++) send(W'(k) * 24'h000101, k == NS - 1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t1_start_not_yet", start1, 0);
    tick();
    chk("t1_start", start1, 1);
    chk("t1_frame_cnt", frame_cnt1, 1);
    chk("t1_xn_bus", xn1, frame_of(24'h0, 24'h000101));
    busy_n = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy1 === 1'b1) busy_n++;
      tick();
    end
    chk("t1_busy_cycles", busy_n, 8);
    chk("t1_start_count", st_n1, 1);

    // Back-to-back frames
    send_frame(24'h100000, 1'b1);
    send_frame(24'h200000, 1'b1);
    wait_starts(1'b0, 3, "t2_start_timeout");
    chk("t2_spacing", st_cyc1[2] - st_cyc1[1], 33);
    chk("t2_first_frame", st_xn1[1], fa);
    chk("t2_second_frame", xn1, fb);
    chk("t2_frame_cnt", frame_cnt1, 3);
    chk("t2_xn_stable", xn_viol, 0);

    // Hold stall with a 40-cycle window
    sel = 1'b1;
    send_frame(24'h100000, 1'b1);
    send_frame(24'h200000, 1'b1);
    chk("t3_ready_stalled", in_ready2, 0);
    chk("t3_busy", busy2, 1);
    chk("t3_held_frame", xn2, fa);
    wait_starts(1'b1, 2, "t3_start_timeout");
    chk("t3_spacing", st_cyc2[1] - st_cyc2[0], 41);
    chk("t3_second_frame", xn2, fb);
    chk("t3_frame_cnt", frame_cnt2, 2);
    sel = 1'b0;

    // Early in_last on sample 10
    for (int k = 0; k <= 10; k++) send(24'h0A0000 + W'(k), k == 10);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t4_frame_err", frame_err1, 1);
    tick();
    chk("t4_frame_err_clear", frame_err1, 0);
    repeat (5) tick();
    chk("t4_no_start", st_n1, 3);
    send_frame(24'h300000, 1'b1);
    wait_starts(1'b0, 4, "t4_start_timeout");
    chk("t4_reload_frame", xn1, frame_of(24'h300000, 24'd1));
    chk("t4_frame_cnt", frame_cnt1, 4);
    chk("t4_err_count", err_n1, 1);

    // Missing in_last
    send_frame(24'h400000, 1'b0);
    chk("t5_frame_err", frame_err1, 1);
    repeat (5) tick();
    chk("t5_no_start", st_n1, 4);
    chk("t5_frame_cnt", frame_cnt1, 4);
    chk("t5_err_count", err_n1, 2);
    chk("t5_xn_kept", xn1, frame_of(24'h300000, 24'd1));

    // Reset in the middle of a hold window
    send_frame(24'h500000, 1'b1);
    wait_starts(1'b0, 5, "t6_start_timeout");
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    chk("t6_rst_xn_bus", xn1, 0);
    chk("t6_rst_busy", busy1, 0);
    chk("t6_rst_in_ready", in_ready1, 0);
    chk("t6_rst_frame_cnt", frame_cnt1, 0);
    repeat (2) tick();
    chk("t6_rst_in_ready_held", in_ready1, 0);
    rst_n = 1'b1;
    tick();
    send_frame(24'h600000, 1'b1);
    wait_starts(1'b0, 6, "t6_start_after_reset");
    chk("t6_frame_cnt", frame_cnt1, 1);
    chk("t6_fresh_frame", xn1, frame_of(24'h600000, 24'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
